// File: rtl/armleocpu_tlb_pkg.sv
// Shared TLB definitions: command encodings and page-number field widths.
// Used by the TLB, its way storage, and any client issuing TLB commands.
// No logic; types and constants only.
package armleocpu_tlb_pkg;

   localparam int VPN_W  = 20;
   localparam int PPN_W  = 22;
   localparam int ATAG_W = 8;

   typedef enum logic [1:0] {
      TLB_CMD_NONE       = 2'd0,
      TLB_CMD_RESOLVE    = 2'd1,
      TLB_CMD_WRITE      = 2'd2,
      TLB_CMD_INVALIDATE = 2'd3
   } tlb_cmd_t;

endpackage

// File: rtl/armleocpu_tlb_way.sv
// One TLB way: per-set valid/tag/accesstag/phys storage plus tag compare.
// Latency: combinational read/compare at idx_i; writes and invalidates land at the next edge.
// Backpressure: none; one operation per cycle is guaranteed by the parent.
module armleocpu_tlb_way
   import armleocpu_tlb_pkg::*;
#(
   parameter int ENTRIES_W = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ENTRIES_W-1:0]         idx_i,
   input  logic [VPN_W-ENTRIES_W-1:0]   tag_i,
   input  logic                         we_i,
   input  logic [ATAG_W-1:0]            accesstag_w_i,
   input  logic [PPN_W-1:0]             phys_w_i,
   input  logic                         inv_i,
   input  logic [ENTRIES_W-1:0]         inv_idx_i,
   output logic                         valid_o,
   output logic                         match_o,
   output logic [ATAG_W-1:0]            accesstag_o,
   output logic [PPN_W-1:0]             phys_o
);

   localparam int SETS  = 2 ** ENTRIES_W;
   localparam int TAG_W = VPN_W - ENTRIES_W;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q       [SETS];
   logic [ATAG_W-1:0] accesstag_q [SETS];
   logic [PPN_W-1:0]  phys_q      [SETS];

   // Valid bits: cleared on reset, set by a write, cleared per set by invalidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx_i] <= 1'b1;
      end else if (inv_i) begin
         valid_q[inv_idx_i] <= 1'b0;
      end
   end

   // Tag and payload arrays carry no reset; the valid bit qualifies them.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[idx_i]       <= tag_i;
         accesstag_q[idx_i] <= accesstag_w_i;
         phys_q[idx_i]      <= phys_w_i;
      end
   end

   assign valid_o     = valid_q[idx_i];
   assign match_o     = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
   assign accesstag_o = accesstag_q[idx_i];
   assign phys_o      = phys_q[idx_i];

endmodule

// File: rtl/armleocpu_tlb.sv
// Set-associative TLB: RESOLVE lookup, WRITE with match/invalid/round-robin victim, INVALIDATE per set.
// Latency: resolve result registered, valid one cycle after the command edge; updates visible next cycle.
// Backpressure: none; exactly one command accepted every cycle.
module armleocpu_tlb
   import armleocpu_tlb_pkg::*;
#(
   parameter int ENTRIES_W = 1,
   parameter int WAYS_W    = 1,
   parameter int DEBUG     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            command,
   input  logic [ENTRIES_W-1:0]  invalidate_set_index,
   input  logic [VPN_W-1:0]      virtual_address_w,
   input  logic [ATAG_W-1:0]     accesstag_w,
   input  logic [PPN_W-1:0]      phys_w,
   input  logic [VPN_W-1:0]      virtual_address,
   output logic                  hit,
   output logic [ATAG_W-1:0]     accesstag_r,
   output logic [PPN_W-1:0]      phys_r
);

   localparam int SETS  = 2 ** ENTRIES_W;
   localparam int WAYS  = 2 ** WAYS_W;
   localparam int PTR_W = (WAYS_W > 0) ? WAYS_W : 1;
   localparam int TAG_W = VPN_W - ENTRIES_W;

   // Trace hook: DEBUG only ever drives simulation-side printing, never hardware.
   if (DEBUG != 0) begin : g_debug
   end

   tlb_cmd_t cmd;
   logic     is_resolve, is_write, is_inval;

   assign cmd        = tlb_cmd_t'(command);
   assign is_resolve = !rst && (cmd == TLB_CMD_RESOLVE);
   assign is_write   = !rst && (cmd == TLB_CMD_WRITE);
   assign is_inval   = !rst && (cmd == TLB_CMD_INVALIDATE);

   // Writes and lookups share the single read port of each way; only one runs per cycle.
   logic [VPN_W-1:0]     addr;
   logic [ENTRIES_W-1:0] idx;
   logic [TAG_W-1:0]     tag;

   assign addr = is_write ? virtual_address_w : virtual_address;
   assign idx  = addr[ENTRIES_W-1:0];
   assign tag  = addr[VPN_W-1:ENTRIES_W];

   logic [WAYS-1:0]   way_valid, way_match, way_we;
   logic [ATAG_W-1:0] way_atag [WAYS];
   logic [PPN_W-1:0]  way_phys [WAYS];

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      armleocpu_tlb_way #(
         .ENTRIES_W (ENTRIES_W)
      ) u_way (
         .clk           (clk),
         .rst           (rst),
         .idx_i         (idx),
         .tag_i         (tag),
         .we_i          (way_we[g]),
         .accesstag_w_i (accesstag_w),
         .phys_w_i      (phys_w),
         .inv_i         (is_inval),
         .inv_idx_i     (invalidate_set_index),
         .valid_o       (way_valid[g]),
         .match_o       (way_match[g]),
         .accesstag_o   (way_atag[g]),
         .phys_o        (way_phys[g])
      );
   end

   logic [PTR_W-1:0] rr_q [SETS];
   logic [PTR_W-1:0] victim;
   logic             found_match, found_inv, rr_adv;
   logic [PTR_W-1:0] rr_next;

   // Victim choice: re-use a matching way, else the lowest invalid way, else round-robin.
   always_comb begin
      victim      = rr_q[idx];
      found_match = 1'b0;
      found_inv   = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
         if (way_match[i] && !found_match) begin
            victim      = PTR_W'(i);
            found_match = 1'b1;
         end
      end
      if (!found_match) begin
         for (int i = 0; i < WAYS; i++) begin
            if (!way_valid[i] && !found_inv) begin
               victim    = PTR_W'(i);
               found_inv = 1'b1;
            end
         end
      end
      rr_adv = !found_match && !found_inv;
   end

   assign rr_next = PTR_W'(rr_q[idx] + 1'b1) & PTR_W'(WAYS - 1);

   // Per-way write strobes from the chosen victim.
   always_comb begin
      way_we = '0;
      for (int i = 0; i < WAYS; i++) begin
         way_we[i] = is_write && (victim == PTR_W'(i));
      end
   end

   // Round-robin pointers advance only when a write evicts a live, non-matching entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
         end
      end else if (is_write && rr_adv) begin
         rr_q[idx] <= rr_next;
      end
   end

   logic              hit_d, hit_q;
   logic [ATAG_W-1:0] atag_d, atag_q;
   logic [PPN_W-1:0]  phys_d, phys_q;

   // Lookup result: at most one way matches, so an OR-mux selects its payload.
   always_comb begin
      hit_d  = 1'b0;
      atag_d = '0;
      phys_d = '0;
      if (is_resolve) begin
         for (int i = 0; i < WAYS; i++) begin
            if (way_match[i]) begin
               hit_d  = 1'b1;
               atag_d = atag_d | way_atag[i];
               phys_d = phys_d | way_phys[i];
            end
         end
      end
   end

   // Registered lookup outputs; any non-resolve command clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q  <= 1'b0;
         atag_q <= '0;
         phys_q <= '0;
      end else begin
         hit_q  <= hit_d;
         atag_q <= atag_d;
         phys_q <= phys_d;
      end
   end

   assign hit         = hit_q;
   assign accesstag_r = atag_q;
   assign phys_r      = phys_q;

endmodule

// File: tb/tb_armleocpu_tlb.sv
// Directed self-checking bench for armleocpu_tlb with 2 sets x 2 ways.
// Inputs driven on the falling edge; outputs sampled 1 ns after the rising edge.
// Each scenario task checks its own results inline.
module tb_armleocpu_tlb;
   import armleocpu_tlb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  command;
   logic [0:0]  invalidate_set_index;
   logic [19:0] virtual_address_w;
   logic [7:0]  accesstag_w;
   logic [21:0] phys_w;
   logic [19:0] virtual_address;
   logic        hit;
   logic [7:0]  accesstag_r;
   logic [21:0] phys_r;

   int n_cmp = 0;
   int n_err = 0;

   armleocpu_tlb #(.ENTRIES_W(1), .WAYS_W(1), .DEBUG(0)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .command              (command),
      .invalidate_set_index (invalidate_set_index),
      .virtual_address_w    (virtual_address_w),
      .accesstag_w          (accesstag_w),
      .phys_w               (phys_w),
      .virtual_address      (virtual_address),
      .hit                  (hit),
      .accesstag_r          (accesstag_r),
      .phys_r               (phys_r)
   );

   always #5 clk = ~clk;

   task automatic step(input tlb_cmd_t c, input logic [19:0] va, input logic [19:0] vaw,
                       input logic [7:0] at, input logic [21:0] ph, input logic [0:0] si);
      @(negedge clk);
      command              = c;
      virtual_address      = va;
      virtual_address_w    = vaw;
      accesstag_w          = at;
      phys_w               = ph;
      invalidate_set_index = si;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [19:0] vpn, input logic [21:0] ph);
      step(TLB_CMD_WRITE, 20'h0, vpn, 8'hFF, ph, 1'b0);
   endtask

   task automatic res(input logic [19:0] vpn);
      step(TLB_CMD_RESOLVE, vpn, 20'h0, 8'h0, 22'h0, 1'b0);
   endtask

   task automatic inv(input logic [0:0] s);
      step(TLB_CMD_INVALIDATE, 20'h0, 20'h0, 8'h0, 22'h0, s);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b1;
      command = TLB_CMD_RESOLVE;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; command = TLB_CMD_NONE; invalidate_set_index = 1'b0;
      virtual_address = 20'h55; virtual_address_w = 20'h0; accesstag_w = 8'h0; phys_w = 22'h0;
      apply_reset();
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%0b want=0", hit); end
      n_cmp++; if (accesstag_r !== 8'h0) begin n_err++; $display("FAIL reset_atag got=%h want=00", accesstag_r); end
      n_cmp++; if (phys_r !== 22'h0) begin n_err++; $display("FAIL reset_phys got=%h want=0", phys_r); end
      release_reset();
      res(20'h55);
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL empty_resolve_55 hit got=%0b want=0", hit); end
   endtask

   task automatic test_fill();
      logic [19:0] vpns [4];
      logic [21:0] phys [4];
      vpns = '{20'h55, 20'h56, 20'h100, 20'h101};
      phys = '{22'hFE, 22'hF5, 22'hF5, 22'hF5};
      wr(20'h100, 22'hF5);
      wr(20'h101, 22'hF5);
      wr(20'h55, 22'hFE);
      wr(20'h56, 22'hF5);
      for (int i = 0; i < 4; i++) begin
         res(vpns[i]);
         n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL fill_hit vpn=%h got=%0b want=1", vpns[i], hit); end
         n_cmp++; if (accesstag_r !== 8'hFF) begin n_err++; $display("FAIL fill_atag vpn=%h got=%h want=ff", vpns[i], accesstag_r); end
         n_cmp++; if (phys_r !== phys[i]) begin n_err++; $display("FAIL fill_phys vpn=%h got=%h want=%h", vpns[i], phys_r, phys[i]); end
      end
   endtask

   task automatic test_invalidate();
      logic [19:0] vpns [4];
      vpns = '{20'h55, 20'h56, 20'h100, 20'h101};
      inv(1'b0);
      res(20'h101);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL inval_other_set_kept got=%0b want=1", hit); end
      inv(1'b1);
      for (int i = 0; i < 4; i++) begin
         res(vpns[i]);
         n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL inval_miss vpn=%h got=%0b want=0", vpns[i], hit); end
         n_cmp++; if (phys_r !== 22'h0) begin n_err++; $display("FAIL inval_phys vpn=%h got=%h want=0", vpns[i], phys_r); end
      end
   endtask

   task automatic test_replace();
      logic [19:0] vpns [3];
      logic        hits [3];
      logic [21:0] phys [3];
      wr(20'h100, 22'h10);
      wr(20'h56, 22'h77);
      wr(20'h102, 22'h33);
      vpns = '{20'h100, 20'h102, 20'h56};
      hits = '{1'b0, 1'b1, 1'b1};
      phys = '{22'h0, 22'h33, 22'h77};
      for (int i = 0; i < 3; i++) begin
         res(vpns[i]);
         n_cmp++; if (hit !== hits[i]) begin n_err++; $display("FAIL rr0_hit vpn=%h got=%0b want=%0b", vpns[i], hit, hits[i]); end
         n_cmp++; if (phys_r !== phys[i]) begin n_err++; $display("FAIL rr0_phys vpn=%h got=%h want=%h", vpns[i], phys_r, phys[i]); end
      end
      wr(20'h104, 22'h44);
      vpns = '{20'h56, 20'h102, 20'h104};
      hits = '{1'b0, 1'b1, 1'b1};
      phys = '{22'h0, 22'h33, 22'h44};
      for (int i = 0; i < 3; i++) begin
         res(vpns[i]);
         n_cmp++; if (hit !== hits[i]) begin n_err++; $display("FAIL rr1_hit vpn=%h got=%0b want=%0b", vpns[i], hit, hits[i]); end
         n_cmp++; if (phys_r !== phys[i]) begin n_err++; $display("FAIL rr1_phys vpn=%h got=%h want=%h", vpns[i], phys_r, phys[i]); end
      end
   endtask

   task automatic test_overwrite();
      apply_reset();
      release_reset();
      res(20'h102);
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL midreset_discard got=%0b want=0", hit); end
      wr(20'h100, 22'hF5);
      wr(20'h100, 22'hAA);
      res(20'h100);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL ovw_hit got=%0b want=1", hit); end
      n_cmp++; if (phys_r !== 22'hAA) begin n_err++; $display("FAIL ovw_phys got=%h want=aa", phys_r); end
      // The second way must still be free, so this lands there and keeps 0x100.
      wr(20'h102, 22'h11);
      res(20'h100);
      n_cmp++; if (phys_r !== 22'hAA) begin n_err++; $display("FAIL ovw_kept_phys got=%h want=aa", phys_r); end
      res(20'h102);
      n_cmp++; if (phys_r !== 22'h11) begin n_err++; $display("FAIL ovw_freeway_phys got=%h want=11", phys_r); end
   endtask

   task automatic test_clear();
      res(20'h100);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL clr_pre_hit got=%0b want=1", hit); end
      step(TLB_CMD_NONE, 20'h100, 20'h0, 8'h0, 22'h0, 1'b0);
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL clr_none_hit got=%0b want=0", hit); end
      n_cmp++; if (phys_r !== 22'h0) begin n_err++; $display("FAIL clr_none_phys got=%h want=0", phys_r); end
      n_cmp++; if (accesstag_r !== 8'h0) begin n_err++; $display("FAIL clr_none_atag got=%h want=0", accesstag_r); end
      res(20'h102);
      wr(20'h200, 22'h3FFFFF);
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL clr_write_hit got=%0b want=0", hit); end
      res(20'h200);
      n_cmp++; if (phys_r !== 22'h3FFFFF) begin n_err++; $display("FAIL b2b_phys got=%h want=3fffff", phys_r); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_invalidate();
      test_replace();
      test_overwrite();
      test_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
